// File: rtl/gamma_table_loader.sv
// Purpose : double-buffered gamma LUT (R/G/B lookup) with streamed shadow-table load and frame-aligned bank swap.
// Latency : 1 cycle from i_rd_addr to o_rd_data on all three read ports.
// Backpressure: o_cfg_ready drops while a complete shadow table waits for i_frame_start; accepts one byte per cycle otherwise.
//
// Ports:
//   clk, rst_n                    single rising-edge clock, asynchronous active-low reset
//   i_cfg_valid/o_cfg_ready       table byte handshake; i_cfg_data carries entries in index order,
//   i_cfg_data, i_cfg_last        i_cfg_last flags the final entry
//   i_frame_start                 bank-swap point (one-cycle pulse)
//   i_rd_addr[3] / o_rd_data[3]   lookup ports, index 2=R, 1=G, 0=B
//   o_table_valid                 an active table has been committed since reset
//   o_swap_pending                complete shadow table waiting for i_frame_start
//   o_err                         one-cycle pulse when a load is rejected
//
// Optional feature: define GAMMA_MONO_CHECK_EN to reject tables that decrease anywhere.
module gamma_table_loader #(
  parameter int COLOR_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [COLOR_DEPTH-1:0] i_cfg_data,
  input  logic                   i_cfg_last,
  input  logic                   i_frame_start,
  input  logic [COLOR_DEPTH-1:0] i_rd_addr [3],
  output logic [COLOR_DEPTH-1:0] o_rd_data [3],
  output logic                   o_table_valid,
  output logic                   o_swap_pending,
  output logic                   o_err
);

  localparam int DEPTH = 1 << COLOR_DEPTH;
  localparam logic [COLOR_DEPTH-1:0] LAST_IDX = {COLOR_DEPTH{1'b1}};
  localparam logic [COLOR_DEPTH-1:0] ONE      = {{(COLOR_DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [COLOR_DEPTH-1:0] cnt_q, cnt_d;
  logic                   bank_sel_q, bank_sel_d;   // bank currently used for reads
  logic                   table_valid_q, table_valid_d;
  logic                   swap_pending_q, swap_pending_d;
  logic                   err_q, err_d;
  logic [COLOR_DEPTH-1:0] rd_data_q [3];
  logic [COLOR_DEPTH-1:0] rd_data_d [3];

  // Table storage is never reset; o_table_valid masks stale contents.
  logic [COLOR_DEPTH-1:0] bank0 [DEPTH];
  logic [COLOR_DEPTH-1:0] bank1 [DEPTH];

  logic                   wr_en;
  logic [COLOR_DEPTH-1:0] wr_addr;
  logic                   accept;
  logic                   load_bad;

`ifdef GAMMA_MONO_CHECK_EN
  logic [COLOR_DEPTH-1:0] prev_q, prev_d;
  logic                   bad_q, bad_d;
`endif

  assign accept = i_cfg_valid && (state_q != PEND);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bank_sel_d     = bank_sel_q;
    table_valid_d  = table_valid_q;
    swap_pending_d = swap_pending_q;
    err_d          = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = cnt_q;
    load_bad       = 1'b0;
`ifdef GAMMA_MONO_CHECK_EN
    prev_d   = prev_q;
    bad_d    = bad_q;
    // Sticky flag: includes the byte being accepted this cycle.
    load_bad = bad_q || (i_cfg_data < prev_q);
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (i_cfg_last) begin
            // A one-entry table can never be complete.
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = '0;
            cnt_d   = ONE;
            state_d = LOAD;
`ifdef GAMMA_MONO_CHECK_EN
            prev_d = i_cfg_data;
            bad_d  = 1'b0;
`endif
          end
        end
      end

      LOAD: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_addr = cnt_q;
          cnt_d   = cnt_q + ONE;
`ifdef GAMMA_MONO_CHECK_EN
          prev_d = i_cfg_data;
          bad_d  = load_bad;
`endif
          if (i_cfg_last && (cnt_q == LAST_IDX) && !load_bad) begin
            // i_frame_start in this same cycle is deliberately ignored.
            state_d        = PEND;
            swap_pending_d = 1'b1;
            cnt_d          = '0;
          end else if (i_cfg_last || (cnt_q == LAST_IDX)) begin
            // Wrong length (or bad content): drop the shadow table, active stays.
            state_d = IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end

      PEND: begin
        if (i_frame_start) begin
          bank_sel_d     = ~bank_sel_q;
          table_valid_d  = 1'b1;
          swap_pending_d = 1'b0;
          state_d        = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reads use the bank selected before this edge, so a read in the swap
    // cycle still sees the old table.
    for (int k = 0; k < 3; k++) begin
      if (table_valid_q) begin
        rd_data_d[k] = bank_sel_q ? bank1[i_rd_addr[k]] : bank0[i_rd_addr[k]];
      end else begin
        rd_data_d[k] = i_rd_addr[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bank_sel_q     <= 1'b0;
      table_valid_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      err_q          <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        rd_data_q[k] <= '0;
      end
`ifdef GAMMA_MONO_CHECK_EN
      prev_q <= '0;
      bad_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bank_sel_q     <= bank_sel_d;
      table_valid_q  <= table_valid_d;
      swap_pending_q <= swap_pending_d;
      err_q          <= err_d;
      for (int k = 0; k < 3; k++) begin
        rd_data_q[k] <= rd_data_d[k];
      end
`ifdef GAMMA_MONO_CHECK_EN
      prev_q <= prev_d;
      bad_q  <= bad_d;
`endif
    end
  end

  // Writes always land in the shadow bank (the one not selected for reads).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bank_sel_q) begin
        bank0[wr_addr] <= i_cfg_data;
      end else begin
        bank1[wr_addr] <= i_cfg_data;
      end
    end
  end

  assign o_cfg_ready    = (state_q != PEND);
  assign o_table_valid  = table_valid_q;
  assign o_swap_pending = swap_pending_q;
  assign o_err          = err_q;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      o_rd_data[k] = rd_data_q[k];
    end
  end

endmodule

// File: tb/tb_gamma_table_loader.sv
// Testbench for gamma_table_loader: random and directed table loads against a
// queue-based reference model; a monitor checks every output cycle.
module tb_gamma_table_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       frame_start;
  logic [7:0] rd_addr [3];
  logic [7:0] rd_data [3];
  logic       table_valid;
  logic       swap_pending;
  logic       err;

  gamma_table_loader #(.COLOR_DEPTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_data     (cfg_data),
    .i_cfg_last     (cfg_last),
    .i_frame_start  (frame_start),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data),
    .o_table_valid  (table_valid),
    .o_swap_pending (swap_pending),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][7:0] rd;
    logic            valid;
    logic            pend;
    logic            err;
    logic            ready;
  } exp_t;

  exp_t exp_q [$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the active table, the committed-but-not-swapped table,
  // and the bytes of the load in progress.
  logic [7:0] m_active [256];
  logic [7:0] m_shadow [256];
  logic [7:0] load_q [$];
  logic       m_valid;
  logic       m_pending;
  logic [7:0] tbl [256];

  function automatic bit table_ok();
`ifdef GAMMA_MONO_CHECK_EN
    for (int i = 1; i < load_q.size(); i++) begin
      if (load_q[i] < load_q[i-1]) return 1'b0;
    end
`endif
    return 1'b1;
  endfunction

  // Called at the active edge with the inputs that the DUT sampled there.
  task automatic model_step();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.rd[k] = m_valid ? m_active[rd_addr[k]] : rd_addr[k];
    end
    e.err = 1'b0;
    if (m_pending) begin
      if (frame_start) begin
        m_active  = m_shadow;
        m_valid   = 1'b1;
        m_pending = 1'b0;
      end
    end else if (cfg_valid) begin
      if (load_q.size() == 0 && cfg_last) begin
        e.err = 1'b1;
      end else begin
        load_q.push_back(cfg_data);
        if (cfg_last || load_q.size() == 256) begin
          if (cfg_last && load_q.size() == 256 && table_ok()) begin
            for (int i = 0; i < 256; i++) m_shadow[i] = load_q[i];
            m_pending = 1'b1;
          end else begin
            e.err = 1'b1;
          end
          load_q.delete();
        end
      end
    end
    e.valid = m_valid;
    e.pend  = m_pending;
    e.ready = !m_pending;
    exp_q.push_back(e);
  endtask

  task automatic compare(input string name, input exp_t e);
    vectors++;
    if (rd_data[2] !== e.rd[2] || rd_data[1] !== e.rd[1] || rd_data[0] !== e.rd[0] ||
        table_valid !== e.valid || swap_pending !== e.pend || err !== e.err ||
        cfg_ready !== e.ready) begin
      miscompares++;
      $display("FAIL %s t=%0t: got rd=%h/%h/%h valid=%b pend=%b err=%b ready=%b, expected rd=%h/%h/%h valid=%b pend=%b err=%b ready=%b",
               name, $time, rd_data[2], rd_data[1], rd_data[0], table_valid, swap_pending, err, cfg_ready,
               e.rd[2], e.rd[1], e.rd[0], e.valid, e.pend, e.err, e.ready);
    end
  endtask

  // Monitor: one expectation per output cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("cycle", e);
      end
    end
  end

  task automatic step_core(input logic v, input logic [7:0] d, input logic l, input logic fs);
    cfg_valid   = v;
    cfg_data    = d;
    cfg_last    = l;
    frame_start = fs;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic fs);
    for (int k = 0; k < 3; k++) rd_addr[k] = 8'($urandom_range(0, 255));
    step_core(v, d, l, fs);
  endtask

  task automatic idle(input int n, input bit rand_fs);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom), 1'($urandom), rand_fs ? ($urandom_range(0, 3) == 0) : 1'b0);
    end
  endtask

  // fs_mode: 0 = never, 1 = random, 2 = only on the byte at last_at
  task automatic send_bytes(input int n, input int last_at, input bit gaps, input int fs_mode);
    logic fs;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          step(1'b0, 8'($urandom), 1'($urandom), (fs_mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0);
        end
      end
      fs = (fs_mode == 1) ? ($urandom_range(0, 7) == 0) : ((fs_mode == 2) && (i == last_at));
      step(1'b1, tbl[i], i == last_at, fs);
    end
  endtask

  task automatic swap_and_read0();
    for (int k = 0; k < 3; k++) rd_addr[k] = 8'h00;
    step_core(1'b0, 8'h00, 1'b0, 1'b1);
    step_core(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    compare("reset_state", e);
  endtask

  // Asynchronous reset applied away from the clock edges.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    frame_start = 1'b0;
    exp_q.delete();
    load_q.delete();
    m_valid   = 1'b0;
    m_pending = 1'b0;
    #2;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fill_random(input bit sorted);
    logic [7:0] v;
    v = 8'($urandom_range(0, 40));
    for (int i = 0; i < 256; i++) begin
      if (sorted) begin
        tbl[i] = v;
        if (v != 8'hFF && $urandom_range(0, 1) == 1) v = v + 8'd1;
      end else begin
        tbl[i] = 8'($urandom);
      end
    end
  endtask

  initial begin
    int mode;
    rst_n       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_data    = 8'h00;
    cfg_last    = 1'b0;
    frame_start = 1'b0;
    for (int k = 0; k < 3; k++) rd_addr[k] = 8'h00;
    m_valid   = 1'b0;
    m_pending = 1'b0;
    #3;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Identity map before any table is committed.
    rd_addr[2] = 8'h10; rd_addr[1] = 8'h80; rd_addr[0] = 8'hFF;
    step_core(1'b0, 8'h00, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Inverting table; frame_start on the final byte must not swap.
    for (int i = 0; i < 256; i++) tbl[i] = 8'(255 - i);
    send_bytes(256, 255, 1'b0, 2);
    idle(3, 1'b0);
    swap_and_read0();       // swap-cycle read sees identity, next read sees FF

    // Short load (last on byte 99) is rejected.
    fill_random(1'b1);
    send_bytes(100, 99, 1'b1, 0);
    idle(3, 1'b1);

    // Overlength: byte 255 without last is rejected.
    send_bytes(256, 300, 1'b0, 0);
    idle(2, 1'b0);

    // Single byte with last in IDLE is rejected.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Second good table; PEND holds off bytes; swap-cycle read sees old table.
    fill_random(1'b1);
    send_bytes(256, 255, 1'b1, 2);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0);
    swap_and_read0();
    idle(3, 1'b0);

    // entry[5] < entry[4]: rejected with the monotonic check, committed without.
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    tbl[4] = 8'h04;
    tbl[5] = 8'h03;
    send_bytes(256, 255, 1'b0, 0);
    idle(2, 1'b0);
    swap_and_read0();
    idle(3, 1'b0);

    // Reset mid-load and in PEND discards the table.
    fill_random(1'b1);
    send_bytes(50, 300, 1'b0, 0);
    do_reset();
    idle(3, 1'b0);
    send_bytes(256, 255, 1'b0, 0);
    do_reset();
    idle(3, 1'b1);

    // Random mix of good and bad loads with random frame_start pulses.
    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(0, 5);
      fill_random($urandom_range(0, 3) != 0);
      case (mode)
        0, 1:    send_bytes(256, 255, 1'b1, 1);
        2:       send_bytes($urandom_range(2, 255), 300, 1'b1, 1);
        3:       begin
                   int n;
                   n = $urandom_range(1, 255);
                   send_bytes(n, n - 1, 1'b1, 1);
                 end
        4:       send_bytes(256, 300, 1'b1, 1);
        default: begin
                   send_bytes($urandom_range(1, 200), 300, 1'b1, 0);
                   do_reset();
                 end
      endcase
      idle($urandom_range(2, 12), 1'b1);
    end
    idle(3, 1'b0);
    @(negedge clk);
    #1;

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
